// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped output port bank.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package io_pkg;

  // Write mode decoded from the address region a bus write lands in.
  typedef enum logic [2:0] {
    MODE_NONE,
    MODE_LOAD,
    MODE_SET,
    MODE_CLR,
    MODE_PULSE
  } mode_e;

  // Default address map: one REGION_SZ-aligned region per write mode.
  localparam int         DEF_REGION_SZ  = 16;
  localparam logic [7:0] DEF_LOAD_BASE  = 8'hE0;
  localparam logic [7:0] DEF_SET_BASE   = 8'hC0;
  localparam logic [7:0] DEF_CLR_BASE   = 8'hD0;
  localparam logic [7:0] DEF_PULSE_BASE = 8'hB0;

  // Width of a down-counter that must hold values 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/port_out_cell.sv
// One output port register with a one-shot pulse down-counter.
// Latency: writes take effect at the sampling edge; pulse_active is decoded straight from the counter.
// Backpressure: none; a selected write is always accepted.
//
// Ports:
//   clock, reset        bus clock, async active-low reset
//   sel                 this cell is the target of the current write
//   mode                write mode for the current write (only meaningful with sel)
//   data_in             write data
//   port                registered port value
//   pulse_active        high while the pulse counter is non-zero
module port_out_cell
  import io_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PULSE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sel,
  input  mode_e             mode,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] port,
  output logic              pulse_active
);

  localparam int CNT_W = cnt_width(PULSE_CYCLES);

  logic [CNT_W-1:0] cnt;

  // A write to this cell takes priority over the pulse countdown, so a
  // write landing on the expiry edge replaces the zeroing instead of
  // producing a one-cycle glitch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      port <= '0;
      cnt  <= '0;
    end else if (sel) begin
      case (mode)
        MODE_LOAD: begin
          port <= data_in;
          cnt  <= '0;
        end
        MODE_SET: begin
          port <= port | data_in;
          cnt  <= '0;
        end
        MODE_CLR: begin
          port <= port & ~data_in;
          cnt  <= '0;
        end
        MODE_PULSE: begin
          port <= data_in;
          cnt  <= CNT_W'(PULSE_CYCLES);
        end
        default: begin
        end
      endcase
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        port <= '0;
      end
    end
  end

  assign pulse_active = (cnt != '0);

endmodule

// File: rtl/port_out_bank.sv
// Bank of memory-mapped output ports with load/set/clear/pulse write aliases and readback.
// Latency: writes land at the sampling edge; readback data_out/read_hit one cycle after the read.
// Backpressure: none; every bus access completes in the cycle it is presented.
//
// Ports:
//   clock, reset        bus clock, async active-low reset
//   address, data_in    bus address and write data
//   write, read         bus strobes, sampled at the rising edge (may coincide)
//   port_out            port i at [i*DATA_W +: DATA_W]
//   pulse_active        bit i high while port i is pulsing
//   data_out, read_hit  registered readback of the load region
module port_out_bank
  import io_pkg::*;
#(
  parameter int              DATA_W       = 8,
  parameter int              ADDR_W       = 8,
  parameter int              N_PORTS      = 16,
  parameter int              REGION_SZ    = DEF_REGION_SZ,
  parameter logic [ADDR_W-1:0] LOAD_BASE  = ADDR_W'(DEF_LOAD_BASE),
  parameter logic [ADDR_W-1:0] SET_BASE   = ADDR_W'(DEF_SET_BASE),
  parameter logic [ADDR_W-1:0] CLR_BASE   = ADDR_W'(DEF_CLR_BASE),
  parameter logic [ADDR_W-1:0] PULSE_BASE = ADDR_W'(DEF_PULSE_BASE),
  parameter int              PULSE_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         address,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      write,
  input  logic                      read,
  output logic [N_PORTS*DATA_W-1:0] port_out,
  output logic [N_PORTS-1:0]        pulse_active,
  output logic [DATA_W-1:0]         data_out,
  output logic                      read_hit
);

  // One bit wider than the address so N_PORTS == 2**ADDR_W still compares.
  localparam logic [ADDR_W:0] NP = (ADDR_W + 1)'(N_PORTS);

  // Only the first N_PORTS slots of a region decode; the rest of the
  // region is a hole that ignores accesses.
  function automatic logic in_region(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] off;
    off = a - base;
    return (a >= base) && ({1'b0, off} < NP);
  endfunction

  logic load_hit, set_hit, clr_hit, pulse_hit;

  assign load_hit  = in_region(address, LOAD_BASE);
  assign set_hit   = in_region(address, SET_BASE);
  assign clr_hit   = in_region(address, CLR_BASE);
  assign pulse_hit = in_region(address, PULSE_BASE);

  mode_e             wr_mode;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] load_idx;

  assign load_idx = address - LOAD_BASE;

  always_comb begin
    wr_mode = MODE_NONE;
    wr_idx  = '0;
    if (write) begin
      if (load_hit) begin
        wr_mode = MODE_LOAD;
        wr_idx  = address - LOAD_BASE;
      end else if (set_hit) begin
        wr_mode = MODE_SET;
        wr_idx  = address - SET_BASE;
      end else if (clr_hit) begin
        wr_mode = MODE_CLR;
        wr_idx  = address - CLR_BASE;
      end else if (pulse_hit) begin
        wr_mode = MODE_PULSE;
        wr_idx  = address - PULSE_BASE;
      end
    end
  end

  logic [DATA_W-1:0] cell_q [N_PORTS];

  for (genvar k = 0; k < N_PORTS; k++) begin : g_cell
    logic sel;
    assign sel = (wr_mode != MODE_NONE) && (wr_idx == ADDR_W'(k));

    port_out_cell #(
      .DATA_W       (DATA_W),
      .PULSE_CYCLES (PULSE_CYCLES)
    ) u_cell (
      .clock        (clock),
      .reset        (reset),
      .sel          (sel),
      .mode         (wr_mode),
      .data_in      (data_in),
      .port         (cell_q[k]),
      .pulse_active (pulse_active[k])
    );

    assign port_out[k*DATA_W +: DATA_W] = cell_q[k];
  end

  // Readback sees the register values before any write on the same edge.
  logic [DATA_W-1:0] rd_dat;

  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (load_idx == ADDR_W'(k)) begin
        rd_dat = cell_q[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      read_hit <= 1'b0;
    end else begin
      read_hit <= read && load_hit;
      if (read) begin
        data_out <= load_hit ? rd_dat : '0;
      end
    end
  end

endmodule

// File: doc/port_out_bank.md
Name: port_out_bank

Overview:
- Parametrised bank of memory-mapped output ports on the CPU I/O bus.
- Replaces the fixed 16 x 8-bit write-only port block.
- Adds four write modes per port: load, bit-set, bit-clear and timed one-shot pulse.
- Adds registered readback of every port and a per-port pulse-active flag.

Parameters:
- DATA_W, 8: port and bus data width.
- ADDR_W, 8: bus address width.
- N_PORTS, 16: number of ports; must be >= 1 and <= REGION_SZ.
- REGION_SZ, 16: size of each address region; power of two; every base below is aligned to it.
- LOAD_BASE, 8'hE0: base of the load / readback region.
- SET_BASE, 8'hC0: base of the bit-set alias region.
- CLR_BASE, 8'hD0: base of the bit-clear alias region.
- PULSE_BASE, 8'hB0: base of the one-shot pulse region.
- PULSE_CYCLES, 16: pulse length in clock cycles; must be >= 1.

Ports:
- clock  in  1  bus clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  bus address.
- data_in  in  DATA_W  write data.
- write  in  1  write strobe, sampled at the rising edge.
- read  in  1  read strobe, sampled at the rising edge.
- port_out  out  N_PORTS*DATA_W  port i occupies bits [i*DATA_W +: DATA_W].
- pulse_active  out  N_PORTS  bit i high while port i is in a pulse.
- data_out  out  DATA_W  registered readback data.
- read_hit  out  1  registered; high when the previous-cycle read hit the load region.

Behaviour:
- Reset (reset low, async): all port_out = 0, all pulse counters = 0, pulse_active = 0, data_out = 0, read_hit = 0.
- Decode: port index i = address - base. A hit requires address in [base, base + N_PORTS - 1]. Addresses in [base + N_PORTS, base + REGION_SZ - 1] and outside all regions are ignored.
- Write with write = 1, effect at the same clock edge:
  - load hit: port[i] <= data_in; pulse counter i cleared.
  - set hit: port[i] <= port[i] | data_in; pulse counter i cleared.
  - clr hit: port[i] <= port[i] & ~data_in; pulse counter i cleared.
  - pulse hit: port[i] <= data_in; counter i <= PULSE_CYCLES. A pulse write to an already-pulsing port restarts the pulse with the new data.
- Pulse timing:
  - Each edge with counter i != 0 and no write to port i: counter decrements.
  - On the edge where the counter goes 1 -> 0, port[i] <= 0.
  - Net effect: the pulse data is visible for exactly PULSE_CYCLES cycles after the write edge.
  - pulse_active[i] = (counter i != 0), decoded from the register (no extra latency).
- Simultaneous pulse expiry and write to the same port in the same cycle: the write wins; there is no zero glitch.
- Readback (1-cycle latency):
  - When read = 1 with a load-region hit: data_out <= port[i] value before any same-edge write (old value); read_hit <= 1.
  - Read miss, including a read addressed to the set/clr/pulse regions: data_out <= 0; read_hit <= 0.
  - read = 0: data_out holds its value; read_hit <= 0.
- read and write in the same cycle are legal and independent.
- Reset asserted mid-pulse aborts the pulse immediately: port = 0, counter = 0.
- Counter width: $clog2(PULSE_CYCLES + 1).

Decomposition:
- Shared package io_pkg holds:
  - the write-mode enum MODE_NONE/LOAD/SET/CLR/PULSE;
  - default region bases E0/C0/D0/B0 and REGION_SZ;
  - a function for counter width.
- One natural sub-module, port_out_cell: a single DATA_W register plus pulse counter, taking a mode, data_in and a one-hot select. It is instantiated N_PORTS times by a generate loop.
- The top level keeps address decode and the readback mux/register.

Test Plan:
- Reset, then load E0 <= 8'hA5 and EF <= 8'h3C -> port0 = A5, port15 = 3C, others 00. Read E0 -> next cycle data_out = A5, read_hit = 1.
- port3 = 8'hF0; set C3 <= 8'h0F -> port3 = FF; clr D3 <= 8'h81 -> port3 = 7E. Writes to F0 or E0 + N_PORTS (with N_PORTS < 16) -> no port changes.
- Pulse B5 <= 8'h55 with PULSE_CYCLES = 4 -> port5 = 55 and pulse_active[5] = 1 for exactly 4 cycles, then port5 = 00 and pulse_active[5] = 0.
- Pulse B5 <= 8'h11, then load E5 <= 8'h22 on the expiry cycle -> port5 = 22 persists and pulse_active[5] = 0. Repeat with a second pulse of 8'h33 mid-pulse -> the count restarts at 4.
- Same-cycle read and write E2 (old 8'h01, new 8'h02) -> data_out = 01, port2 = 02.
- Assert reset asynchronously mid-pulse and between clock edges -> all outputs 00 immediately. After release, a read of C0 returns data_out = 00 with read_hit = 0.
